// File: rtl/car_traffic_controller.sv
// Four-lane car position generator: per-lane tick dividers, level-scaled step,
// screen-width wrap, and an IDLE/RUN/FREEZE control FSM with registered outputs.
module car_traffic_controller #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int BASE_STEP     = 2,
  parameter int LANE_DIV1     = 1,
  parameter int LANE_DIV2     = 2,
  parameter int LANE_DIV3     = 3,
  parameter int LANE_DIV4     = 4,
  parameter int INIT_X1       = 0,
  parameter int INIT_X2       = 160,
  parameter int INIT_X3       = 320,
  parameter int INIT_X4       = 480,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       collision,
  input  logic       level_up,
  input  logic       restart,
  output logic [9:0] car_x1,
  output logic [9:0] car_x2,
  output logic [9:0] car_x3,
  output logic [9:0] car_x4,
  output logic [2:0] level,
  output logic       moving,
  output logic       frozen
);

  typedef enum logic [1:0] {IDLE, RUN, FREEZE} state_t;

  localparam int FW = (FREEZE_FRAMES > 1) ? $clog2(FREEZE_FRAMES) : 1;
  localparam logic [10:0] SW = 11'(SCREEN_WIDTH);
  localparam logic [7:0] D1 = 8'(LANE_DIV1 - 1);
  localparam logic [7:0] D2 = 8'(LANE_DIV2 - 1);
  localparam logic [7:0] D3 = 8'(LANE_DIV3 - 1);
  localparam logic [7:0] D4 = 8'(LANE_DIV4 - 1);
  localparam logic [FW-1:0] FREEZE_LAST = FW'(FREEZE_FRAMES - 1);

  state_t        state;
  logic [7:0]    cnt1, cnt2, cnt3, cnt4;
  logic [FW-1:0] freeze_cnt;
  logic [10:0]   step;

  // Step uses the level as registered now, so a same-cycle level_up affects only later moves.
  assign step = 11'(BASE_STEP) + {8'd0, level};

  function automatic logic [9:0] move_right(input logic [9:0] x, input logic [10:0] s);
    logic [10:0] sum;
    sum = {1'b0, x} + s;
    if (sum >= SW) sum = sum - SW;
    return sum[9:0];
  endfunction

  function automatic logic [9:0] move_left(input logic [9:0] x, input logic [10:0] s);
    logic [10:0] r;
    if ({1'b0, x} >= s) r = {1'b0, x} - s;
    else                r = {1'b0, x} + SW - s;
    return r[9:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      car_x1     <= 10'(INIT_X1);
      car_x2     <= 10'(INIT_X2);
      car_x3     <= 10'(INIT_X3);
      car_x4     <= 10'(INIT_X4);
      level      <= 3'd0;
      cnt1       <= 8'd0;
      cnt2       <= 8'd0;
      cnt3       <= 8'd0;
      cnt4       <= 8'd0;
      freeze_cnt <= '0;
      moving     <= 1'b0;
      frozen     <= 1'b0;
    end else if (restart) begin
      state      <= IDLE;
      car_x1     <= 10'(INIT_X1);
      car_x2     <= 10'(INIT_X2);
      car_x3     <= 10'(INIT_X3);
      car_x4     <= 10'(INIT_X4);
      level      <= 3'd0;
      cnt1       <= 8'd0;
      cnt2       <= 8'd0;
      cnt3       <= 8'd0;
      cnt4       <= 8'd0;
      freeze_cnt <= '0;
      moving     <= 1'b0;
      frozen     <= 1'b0;
    end else begin
      if (level_up && level != 3'd7) level <= level + 3'd1;
      case (state)
        IDLE: begin
          if (run) begin
            state  <= RUN;
            moving <= 1'b1;
          end
        end
        RUN: begin
          if (collision) begin
            state      <= FREEZE;
            freeze_cnt <= '0;
            moving     <= 1'b0;
            frozen     <= 1'b1;
          end else if (frame_tick && run) begin
            if (cnt1 == D1) begin car_x1 <= move_right(car_x1, step); cnt1 <= 8'd0; end
            else cnt1 <= cnt1 + 8'd1;
            if (cnt2 == D2) begin car_x2 <= move_left(car_x2, step);  cnt2 <= 8'd0; end
            else cnt2 <= cnt2 + 8'd1;
            if (cnt3 == D3) begin car_x3 <= move_right(car_x3, step); cnt3 <= 8'd0; end
            else cnt3 <= cnt3 + 8'd1;
            if (cnt4 == D4) begin car_x4 <= move_left(car_x4, step);  cnt4 <= 8'd0; end
            else cnt4 <= cnt4 + 8'd1;
          end
        end
        FREEZE: begin
          // Collisions are ignored here so the freeze window cannot be extended.
          if (frame_tick) begin
            if (freeze_cnt == FREEZE_LAST) begin
              state      <= RUN;
              freeze_cnt <= '0;
              moving     <= 1'b1;
              frozen     <= 1'b0;
            end else begin
              freeze_cnt <= freeze_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_car_traffic_controller.sv
// Directed self-checking bench for car_traffic_controller: motion, wrap, freeze,
// level scaling, restart and asynchronous reset.
module tb_car_traffic_controller;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       run;
  logic       collision;
  logic       level_up;
  logic       restart;
  logic [9:0] car_x1, car_x2, car_x3, car_x4;
  logic [2:0] level;
  logic       moving;
  logic       frozen;

  int total = 0;
  int bad   = 0;

  car_traffic_controller dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run),
    .collision(collision), .level_up(level_up), .restart(restart),
    .car_x1(car_x1), .car_x2(car_x2), .car_x3(car_x3), .car_x4(car_x4),
    .level(level), .moving(moving), .frozen(frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [39:0] pos = {car_x1, car_x2, car_x3, car_x4};

  // One clock with an optional frame tick; pulses are cleared after the edge.
  task automatic cyc(input logic t);
    frame_tick = t;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    level_up   = 1'b0;
    restart    = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; frame_tick = 1'b0; run = 1'b0; collision = 1'b0;
    level_up = 1'b0; restart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    total++;
    if (pos !== {10'd0, 10'd160, 10'd320, 10'd480}) begin
      bad++; $display("[TB] FAIL reset_pos got %0d/%0d/%0d/%0d want 0/160/320/480", car_x1, car_x2, car_x3, car_x4);
    end
    total++;
    if ({level, moving, frozen} !== {3'd0, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL reset_flags got level=%0d moving=%b frozen=%b want 0/0/0", level, moving, frozen);
    end
    run_ticks(3);
    total++;
    if ({pos, moving} !== {10'd0, 10'd160, 10'd320, 10'd480, 1'b0}) begin
      bad++; $display("[TB] FAIL idle_ticks got %0d/%0d/%0d/%0d moving=%b want 0/160/320/480 moving=0", car_x1, car_x2, car_x3, car_x4, moving);
    end
  endtask

  task automatic test_basic;
    run = 1'b1;
    cyc(1'b0);
    total++;
    if (moving !== 1'b1) begin
      bad++; $display("[TB] FAIL enter_run got moving=%b want 1", moving);
    end
    cyc(1'b1);
    total++;
    if (pos !== {10'd2, 10'd160, 10'd320, 10'd480}) begin
      bad++; $display("[TB] FAIL tick1 got %0d/%0d/%0d/%0d want 2/160/320/480", car_x1, car_x2, car_x3, car_x4);
    end
    cyc(1'b1);
    total++;
    if (pos !== {10'd4, 10'd158, 10'd320, 10'd480}) begin
      bad++; $display("[TB] FAIL tick2 got %0d/%0d/%0d/%0d want 4/158/320/480", car_x1, car_x2, car_x3, car_x4);
    end
  endtask

  task automatic test_wrap;
    run_ticks(158);
    total++;
    if (pos !== {10'd320, 10'd0, 10'd426, 10'd400}) begin
      bad++; $display("[TB] FAIL t160 got %0d/%0d/%0d/%0d want 320/0/426/400", car_x1, car_x2, car_x3, car_x4);
    end
    cyc(1'b1);
    total++;
    if (pos !== {10'd322, 10'd0, 10'd426, 10'd400}) begin
      bad++; $display("[TB] FAIL t161 got %0d/%0d/%0d/%0d want 322/0/426/400", car_x1, car_x2, car_x3, car_x4);
    end
    cyc(1'b1);
    total++;
    if (pos !== {10'd324, 10'd638, 10'd428, 10'd400}) begin
      bad++; $display("[TB] FAIL lane2_wrap got %0d/%0d/%0d/%0d want 324/638/428/400", car_x1, car_x2, car_x3, car_x4);
    end
    run_ticks(157);
    total++;
    if (pos !== {10'd638, 10'd482, 10'd532, 10'd322}) begin
      bad++; $display("[TB] FAIL t319 got %0d/%0d/%0d/%0d want 638/482/532/322", car_x1, car_x2, car_x3, car_x4);
    end
    cyc(1'b1);
    total++;
    if (pos !== {10'd0, 10'd480, 10'd532, 10'd320}) begin
      bad++; $display("[TB] FAIL lane1_wrap got %0d/%0d/%0d/%0d want 0/480/532/320", car_x1, car_x2, car_x3, car_x4);
    end
  endtask

  task automatic test_collision;
    collision = 1'b1;
    cyc(1'b1);
    total++;
    if ({pos, moving, frozen} !== {10'd0, 10'd480, 10'd532, 10'd320, 1'b0, 1'b1}) begin
      bad++; $display("[TB] FAIL collide got %0d/%0d/%0d/%0d m=%b f=%b want 0/480/532/320 m=0 f=1", car_x1, car_x2, car_x3, car_x4, moving, frozen);
    end
    run_ticks(10);
    collision = 1'b0;
    run_ticks(49);
    total++;
    if ({pos, moving, frozen} !== {10'd0, 10'd480, 10'd532, 10'd320, 1'b0, 1'b1}) begin
      bad++; $display("[TB] FAIL freeze59 got %0d/%0d/%0d/%0d m=%b f=%b want 0/480/532/320 m=0 f=1", car_x1, car_x2, car_x3, car_x4, moving, frozen);
    end
    cyc(1'b1);
    total++;
    if ({pos, moving, frozen} !== {10'd0, 10'd480, 10'd532, 10'd320, 1'b1, 1'b0}) begin
      bad++; $display("[TB] FAIL freeze60 got %0d/%0d/%0d/%0d m=%b f=%b want 0/480/532/320 m=1 f=0", car_x1, car_x2, car_x3, car_x4, moving, frozen);
    end
    cyc(1'b1);
    total++;
    if (pos !== {10'd2, 10'd480, 10'd534, 10'd320}) begin
      bad++; $display("[TB] FAIL resume_move got %0d/%0d/%0d/%0d want 2/480/534/320", car_x1, car_x2, car_x3, car_x4);
    end
  endtask

  task automatic test_level;
    level_up = 1'b1;
    cyc(1'b1);
    total++;
    if ({pos, level} !== {10'd4, 10'd478, 10'd534, 10'd320, 3'd1}) begin
      bad++; $display("[TB] FAIL lvl_same_tick got %0d/%0d/%0d/%0d lvl=%0d want 4/478/534/320 lvl=1", car_x1, car_x2, car_x3, car_x4, level);
    end
    for (int i = 0; i < 8; i++) begin
      level_up = 1'b1;
      cyc(1'b0);
    end
    total++;
    if (level !== 3'd7) begin
      bad++; $display("[TB] FAIL lvl_saturate got %0d want 7", level);
    end
    cyc(1'b1);
    total++;
    if (pos !== {10'd13, 10'd478, 10'd534, 10'd320}) begin
      bad++; $display("[TB] FAIL step9_a got %0d/%0d/%0d/%0d want 13/478/534/320", car_x1, car_x2, car_x3, car_x4);
    end
    cyc(1'b1);
    total++;
    if (pos !== {10'd22, 10'd469, 10'd543, 10'd311}) begin
      bad++; $display("[TB] FAIL step9_b got %0d/%0d/%0d/%0d want 22/469/543/311", car_x1, car_x2, car_x3, car_x4);
    end
    run = 1'b0;
    run_ticks(2);
    total++;
    if ({pos, moving} !== {10'd22, 10'd469, 10'd543, 10'd311, 1'b1}) begin
      bad++; $display("[TB] FAIL run_low_hold got %0d/%0d/%0d/%0d m=%b want 22/469/543/311 m=1", car_x1, car_x2, car_x3, car_x4, moving);
    end
    run = 1'b1;
  endtask

  task automatic test_restart;
    collision = 1'b1;
    cyc(1'b0);
    collision = 1'b0;
    run_ticks(3);
    total++;
    if (frozen !== 1'b1) begin
      bad++; $display("[TB] FAIL pre_restart got frozen=%b want 1", frozen);
    end
    restart = 1'b1;
    run = 1'b0;
    cyc(1'b1);
    total++;
    if ({pos, level, moving, frozen} !== {10'd0, 10'd160, 10'd320, 10'd480, 3'd0, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL restart got %0d/%0d/%0d/%0d lvl=%0d m=%b f=%b want 0/160/320/480 lvl=0 m=0 f=0", car_x1, car_x2, car_x3, car_x4, level, moving, frozen);
    end
    run = 1'b1;
    cyc(1'b1);
    total++;
    if ({pos, moving} !== {10'd0, 10'd160, 10'd320, 10'd480, 1'b1}) begin
      bad++; $display("[TB] FAIL idle_to_run got %0d/%0d/%0d/%0d m=%b want 0/160/320/480 m=1", car_x1, car_x2, car_x3, car_x4, moving);
    end
    cyc(1'b1);
    total++;
    if (pos !== {10'd2, 10'd160, 10'd320, 10'd480}) begin
      bad++; $display("[TB] FAIL first_after_restart got %0d/%0d/%0d/%0d want 2/160/320/480", car_x1, car_x2, car_x3, car_x4);
    end
  endtask

  task automatic test_async_reset;
    level_up = 1'b1;
    cyc(1'b1);
    total++;
    if ({pos, level} !== {10'd4, 10'd158, 10'd320, 10'd480, 3'd1}) begin
      bad++; $display("[TB] FAIL pre_reset got %0d/%0d/%0d/%0d lvl=%0d want 4/158/320/480 lvl=1", car_x1, car_x2, car_x3, car_x4, level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({pos, level, moving, frozen} !== {10'd0, 10'd160, 10'd320, 10'd480, 3'd0, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL async_reset got %0d/%0d/%0d/%0d lvl=%0d m=%b f=%b want 0/160/320/480 0 0 0", car_x1, car_x2, car_x3, car_x4, level, moving, frozen);
    end
    run = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1);
    total++;
    if ({pos, moving} !== {10'd0, 10'd160, 10'd320, 10'd480, 1'b0}) begin
      bad++; $display("[TB] FAIL post_reset got %0d/%0d/%0d/%0d m=%b want 0/160/320/480 m=0", car_x1, car_x2, car_x3, car_x4, moving);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_collision();
    test_level();
    test_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
